spi_master_cfg: RTL and testbench



---
 rtl/spi_master_cfg_if.sv | 28 ++
 rtl/spi_master_cfg.sv | 201 ++++++++++++++++++++
 tb/tb_spi_master_cfg.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_cfg_if.sv
// spi_master_cfg_if: sequencer handshake, mode select and SPI pin bundle.
// Modports: master = sequencer/pin side, slave = spi_master_cfg engine.
interface spi_master_cfg_if #(
  parameter int DATA_W = 8
);
  logic              cpol;
  logic              cpha;
  logic              req;
  logic [DATA_W-1:0] din;
  logic              finish;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] dout;
  logic              spi_sclk;
  logic              spi_miso;
  logic              spi_mosi;
  logic              spi_cs;

  modport master (
    output cpol, cpha, req, din, finish, spi_miso,
    input  busy, done, dout, spi_sclk, spi_mosi, spi_cs
  );

  modport slave (
    input  cpol, cpha, req, din, finish, spi_miso,
    output busy, done, dout, spi_sclk, spi_mosi, spi_cs
  );
endinterface

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: SPI master, DATA_W-bit words, CLK_DIV divider, CPOL/CPHA.
// Ports: clk, rst_n (async low), bus (slave modport). Macro SPI_LSB_FIRST_EN.
module spi_master_cfg #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_master_cfg_if.slave bus
);
  localparam int H    = CLK_DIV / 2;
  localparam int NE   = 2 * DATA_W;
  localparam int CMAX = (H > CS_GAP) ? H : CS_GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int EW   = $clog2(NE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_XFER, S_WAIT, S_TRAIL, S_GAP
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [CW-1:0]     r_cnt;
  logic [EW-1:0]     r_edge;
  logic              r_cpha;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_dout;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_cs;
  logic              r_done;
  logic              r_busy;

  logic w_h_end;
  logic w_gap_end;
  logic w_last;
  logic w_load;
  logic w_edge;
  logic w_fin;
  logic w_cs_up;
  logic w_cnt_clr;
  logic w_sample;
  logic w_cpha;

`ifdef SPI_LSB_FIRST_EN
  function automatic logic f_bit(
    input logic [DATA_W-1:0] v);
    return v[0];
  endfunction
  function automatic logic [DATA_W-1:0] f_shift(
    input logic [DATA_W-1:0] v);
    return v >> 1;
  endfunction
  function automatic logic [DATA_W-1:0] f_rx(
    input logic [DATA_W-1:0] v, input logic b);
    return {b, v[DATA_W-1:1]};
  endfunction
`else
  function automatic logic f_bit(
    input logic [DATA_W-1:0] v);
    return v[DATA_W-1];
  endfunction
  function automatic logic [DATA_W-1:0] f_shift(
    input logic [DATA_W-1:0] v);
    return v << 1;
  endfunction
  function automatic logic [DATA_W-1:0] f_rx(
    input logic [DATA_W-1:0] v, input logic b);
    return {v[DATA_W-2:0], b};
  endfunction
`endif

  assign w_h_end   = (r_cnt == CW'(H - 1));
  assign w_gap_end = (r_cnt == CW'(CS_GAP - 1));
  assign w_last    = (r_edge == EW'(NE));
  // Edge number r_edge+1 is leading when odd; cpha flips sample/shift.
  assign w_sample  = ~r_edge[0] ^ r_cpha;
  // Mode is taken live only on the req that opens a frame.
  assign w_cpha    = (r_state == S_IDLE) ? bus.cpha : r_cpha;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_load    = 1'b0;
    w_edge    = 1'b0;
    w_fin     = 1'b0;
    w_cs_up   = 1'b0;
    w_cnt_clr = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (bus.req) begin
          w_nxt  = S_LEAD;
          w_load = 1'b1;
        end
      end
      S_LEAD: begin
        // Edge 1 fires as LEAD ends.
        if (w_h_end) begin
          w_nxt     = S_XFER;
          w_edge    = 1'b1;
          w_cnt_clr = 1'b1;
        end
      end
      S_XFER: begin
        if (w_last) begin
          w_nxt     = S_WAIT;
          w_fin     = 1'b1;
          w_cnt_clr = 1'b1;
        end else if (w_h_end) begin
          w_edge    = 1'b1;
          w_cnt_clr = 1'b1;
        end
      end
      S_WAIT: begin
        w_cnt_clr = 1'b1;
        if (bus.finish) begin
          w_nxt = S_TRAIL;
        end else if (bus.req) begin
          w_nxt  = S_XFER;
          w_load = 1'b1;
        end
      end
      S_TRAIL: begin
        if (w_h_end) begin
          w_nxt     = S_GAP;
          w_cs_up   = 1'b1;
          w_cnt_clr = 1'b1;
        end
      end
      S_GAP: begin
        if (w_gap_end) begin
          w_nxt     = S_IDLE;
          w_cnt_clr = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_edge <= '0;
      r_cpha <= 1'b0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_dout <= '0;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_cs   <= 1'b1;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_clr ? '0 : r_cnt + CW'(1);
      r_done <= w_fin;
      r_busy <= (w_nxt != S_IDLE);
      if (w_fin) r_dout <= r_rx;
      if (w_load) begin
        r_edge <= '0;
        if (r_state == S_IDLE) begin
          r_cpha <= bus.cpha;
          r_sclk <= bus.cpol;
          r_cs   <= 1'b0;
        end
        // cpha=0 presents the first bit before edge 1.
        if (w_cpha) begin
          r_tx <= bus.din;
        end else begin
          r_tx   <= f_shift(bus.din);
          r_mosi <= f_bit(bus.din);
        end
      end
      if (w_edge) begin
        r_edge <= r_edge + EW'(1);
        r_sclk <= ~r_sclk;
        if (w_sample) begin
          r_rx <= f_rx(r_rx, bus.spi_miso);
        end else begin
          r_mosi <= f_bit(r_tx);
          r_tx   <= f_shift(r_tx);
        end
      end
      if (w_cs_up) r_cs <= 1'b1;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.dout     = r_dout;
  assign bus.spi_sclk = r_sclk;
  assign bus.spi_mosi = r_mosi;
  assign bus.spi_cs   = r_cs;
endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: directed vectors and frame sequences for spi_master_cfg.
// DATA_W=8, CLK_DIV=4 (H=2), CS_GAP=2.
module tb_spi_master_cfg;
  logic clk;
  logic rst_n;
  int   cyc;
  int   miso_mode;
  logic cur_cpha;
  int   n_pass;
  int   n_tot;

  spi_master_cfg_if #(.DATA_W(8)) bus();

  spi_master_cfg #(
    .DATA_W(8), .CLK_DIV(4), .CS_GAP(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    bus.spi_miso = 1'b0;
    if (miso_mode == 0) bus.spi_miso = bus.spi_mosi;
    else if (miso_mode == 1) bus.spi_miso = 1'b1;
  end

  // Bus monitor, sampled mid-cycle.
  int       m_e, m_etot, m_rise, m_e1;
  int       m_done, m_done_cyc;
  int       m_csf, m_csr, m_csr_n, m_bf;
  logic [7:0] m_mosi;
  logic     m_pcs = 1'b1;
  logic     m_psclk = 1'b0;
  logic     m_pbusy = 1'b0;

  always @(negedge clk) begin
    if (!bus.spi_cs && !m_pcs && bus.spi_sclk != m_psclk) begin
      m_e++;
      m_etot++;
      if (bus.spi_sclk) m_rise++;
      if (m_e == 1) m_e1 = cyc;
      if (m_e[0] ^ cur_cpha) m_mosi = {m_mosi[6:0], bus.spi_mosi};
    end
    if (bus.done) begin
      m_done++;
      m_done_cyc = cyc;
      m_e = 0;
    end
    if (m_pcs && !bus.spi_cs) m_csf = cyc;
    if (!m_pcs && bus.spi_cs) begin
      m_csr = cyc;
      m_csr_n++;
    end
    if (m_pbusy && !bus.busy) m_bf = cyc;
    m_pcs   = bus.spi_cs;
    m_psclk = bus.spi_sclk;
    m_pbusy = bus.busy;
  end

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] din;
    int         mm;
    logic [7:0] dout;
  } vec_t;

  vec_t vt[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [7:0] exp_mosi(input logic [7:0] d);
    logic [7:0] r;
    r = d;
`ifdef SPI_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
`endif
    return r;
  endfunction

  task automatic clr_mon();
    m_e = 0; m_etot = 0; m_rise = 0; m_e1 = -1;
    m_done = 0; m_done_cyc = -1;
    m_csf = -1; m_csr = -1; m_csr_n = 0; m_bf = -1;
    m_mosi = 8'h00;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 300 && m_done < n; i++) tick();
    if (m_done < n) begin
      n_tot++;
      $display("FAIL done_timeout: got %0d expected %0d", m_done, n);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && bus.busy; i++) tick();
    if (bus.busy) begin
      n_tot++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    int r;
    int f;
    bus.cpol = v.cpol;
    bus.cpha = v.cpha;
    bus.din  = v.din;
    miso_mode = v.mm;
    cur_cpha  = v.cpha;
    clr_mon();
    bus.req = 1'b1;
    r = cyc;
    tick();
    bus.req = 1'b0;
    bus.din = 8'h00;
    wait_done(1);
    tick();
    chk("wait_sclk_idle", bus.spi_sclk, v.cpol);
    chk("wait_cs_low", bus.spi_cs, 1'b0);
    bus.finish = 1'b1;
    f = cyc;
    tick();
    bus.finish = 1'b0;
    wait_idle();
    chk("dout", bus.dout, v.dout);
    chk("mosi_bits", m_mosi, exp_mosi(v.din));
    chk("done_at", m_done_cyc - r, 34);
    chk("done_cnt", m_done, 1);
    chk("sclk_rises", m_rise, 8);
    chk("sclk_edges", m_etot, 16);
    chk("cs_fall_at", m_csf - r, 1);
    chk("edge1_at", m_e1 - r, 3);
    chk("cs_rise_at", m_csr - f, 3);
    chk("busy_fall_at", m_bf - f, 5);
    chk("idle_sclk", bus.spi_sclk, v.cpol);
  endtask

  initial begin
    logic [7:0] words [3];
    int r;
    int f;
    n_pass = 0;
    n_tot  = 0;
    rst_n  = 1'b0;
    bus.req = 1'b0;
    bus.finish = 1'b0;
    bus.din = 8'h00;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    miso_mode = 0;
    cur_cpha  = 1'b0;
    clr_mon();

    vt[0] = '{1'b0, 1'b0, 8'hA5, 0, 8'hA5};
    vt[1] = '{1'b1, 1'b1, 8'h3C, 1, 8'hFF};
    vt[2] = '{1'b0, 1'b1, 8'h96, 2, 8'h00};
    vt[3] = '{1'b1, 1'b0, 8'h5A, 0, 8'h5A};
    vt[4] = '{1'b0, 1'b0, 8'h01, 0, 8'h01};
    vt[5] = '{1'b1, 1'b1, 8'hC1, 0, 8'hC1};

    repeat (3) tick();
    chk("rst_cs", bus.spi_cs, 1'b1);
    chk("rst_sclk", bus.spi_sclk, 1'b0);
    chk("rst_mosi", bus.spi_mosi, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_dout", bus.dout, 8'h00);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Three back-to-back words in one frame.
    words[0] = 8'h02;
    words[1] = 8'h00;
    words[2] = 8'h10;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    miso_mode = 0;
    cur_cpha  = 1'b0;
    clr_mon();
    for (int w = 0; w < 3; w++) begin
      bus.din = words[w];
      bus.req = 1'b1;
      r = cyc;
      tick();
      bus.req = 1'b0;
      wait_done(w + 1);
      chk("multi_dout", bus.dout, words[w]);
      chk("multi_edge1_at", m_e1 - r, 3);
      tick();
    end
    bus.finish = 1'b1;
    f = cyc;
    tick();
    bus.finish = 1'b0;
    wait_idle();
    chk("multi_done_cnt", m_done, 3);
    chk("multi_cs_rises", m_csr_n, 1);
    chk("multi_cs_rise_at", m_csr - f, 3);
    chk("multi_busy_fall_at", m_bf - f, 5);

    // req during XFER, then req+finish together in WAIT.
    bus.din = 8'hA5;
    clr_mon();
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    repeat (8) tick();
    bus.din = 8'hFF;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    wait_done(1);
    tick();
    chk("ign_dout", bus.dout, 8'hA5);
    bus.din = 8'h11;
    bus.req = 1'b1;
    bus.finish = 1'b1;
    f = cyc;
    tick();
    bus.req = 1'b0;
    bus.finish = 1'b0;
    wait_idle();
    repeat (40) tick();
    chk("ign_done_cnt", m_done, 1);
    chk("ign_cs_rise_at", m_csr - f, 3);
    chk("ign_busy_fall_at", m_bf - f, 5);
    chk("ign_dout_hold", bus.dout, 8'hA5);
    chk("ign_busy", bus.busy, 1'b0);

    // Reset at edge 5 of a transfer.
    bus.din = 8'hA5;
    clr_mon();
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    for (int i = 0; i < 200 && m_e < 5; i++) tick();
    chk("rst_mid_edge5", m_e, 5);
    chk("rst_mid_sclk_pre", bus.spi_sclk, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cs", bus.spi_cs, 1'b1);
    chk("rst_mid_sclk", bus.spi_sclk, 1'b0);
    chk("rst_mid_done", bus.done, 1'b0);
    chk("rst_mid_busy", bus.busy, 1'b0);
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("rst_mid_no_done", m_done, 0);
    run_vec(vt[0]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
